jesd204_frame_align_replace_gen: RTL

Generic JESD204B 8b/10b frame-alignment character inserter (TX) / remover (RX) for any octets-per-frame F from 1 to 256 and data path widths of 4 or 8 octets per beat. It runs a free-running frame-position counter and a one-octet "previous end-of-frame" history register, so it needs no per-F delay-line taps. It sits per lane between the link-layer framer/deframer and the 8b/10b encode/decode boundary, with one registered stage.

---
 rtl/jesd204_frame_align_replace_gen_if.sv | 24 ++
 rtl/jesd204_frame_align_replace_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jesd204_frame_align_replace_gen_if.sv
// rtl/jesd204_frame_align_replace_gen_if.sv - per-lane beat bundle for the frame-alignment character stage
interface jesd204_frame_align_replace_gen_if #(
    parameter int DATA_PATH_WIDTH = 4
);
    logic                           in_valid;
    logic                           in_start;
    logic [8*DATA_PATH_WIDTH-1:0]   in_data;
    logic [DATA_PATH_WIDTH-1:0]     in_charisk;
    logic [DATA_PATH_WIDTH-1:0]     in_eomf;
    logic                           out_valid;
    logic [8*DATA_PATH_WIDTH-1:0]   out_data;
    logic [DATA_PATH_WIDTH-1:0]     out_charisk;
    logic                           out_unexpected_char;

    modport master (
        output in_valid, in_start, in_data, in_charisk, in_eomf,
        input  out_valid, out_data, out_charisk, out_unexpected_char
    );

    modport slave (
        input  in_valid, in_start, in_data, in_charisk, in_eomf,
        output out_valid, out_data, out_charisk, out_unexpected_char
    );
endinterface

// File: rtl/jesd204_frame_align_replace_gen.sv
// rtl/jesd204_frame_align_replace_gen.sv - JESD204B /A/ /F/ insert (TX) / remove (RX); stats counters under JESD204_FRAME_ALIGN_STATS_EN
module jesd204_frame_align_replace_gen #(
    parameter int DATA_PATH_WIDTH = 4,
    parameter bit IS_RX           = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cfg_octets_per_frame,
    input  logic        cfg_disable_char_replacement,
    input  logic        cfg_disable_scrambler,
`ifdef JESD204_FRAME_ALIGN_STATS_EN
    output logic [15:0] stat_a_count,
    output logic [15:0] stat_f_count,
`endif
    jesd204_frame_align_replace_gen_if.slave bus
);
    localparam int         DPW    = DATA_PATH_WIDTH;
    localparam logic [7:0] CHAR_A = 8'h7C;
    localparam logic [7:0] CHAR_F = 8'hFC;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    // frame_last holds F-1; base is the frame position of lane 0 of the next beat
    logic [7:0]       frame_last;
    logic [7:0]       frame_last_next;
    logic [7:0]       base;
    logic [7:0]       base_next;
    logic [7:0]       prev_eof;
    logic [7:0]       prev_eof_next;
    logic             prev_repl;
    logic             prev_repl_next;

    logic             start_beat;
    logic             replace_en;
    logic [7:0]       pos;
    logic [7:0]       octet;
    logic [7:0]       hist_data;
    logic             hist_repl;
    logic             is_align_char;

    logic [8*DPW-1:0] data_next;
    logic [DPW-1:0]   charisk_next;
    logic             unexpected_next;
    logic [3:0]       a_events;
    logic [3:0]       f_events;

    // Only one direction uses each of these lane flags.
    logic             unused_inputs;
    assign unused_inputs = ^{bus.in_charisk, bus.in_eomf};

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, lane-by-lane position walk and character replacement.
    always_comb begin
        state_next      = state;
        frame_last_next = frame_last;
        base_next       = base;
        prev_eof_next   = prev_eof;
        prev_repl_next  = prev_repl;
        data_next       = bus.in_data;
        charisk_next    = '0;
        unexpected_next = 1'b0;
        a_events        = 4'd0;
        f_events        = 4'd0;
        octet           = 8'd0;
        is_align_char   = 1'b0;

        start_beat = bus.in_valid && bus.in_start;
        if (start_beat) begin
            state_next      = LOCKED;
            frame_last_next = cfg_octets_per_frame;
        end

        // The start beat itself is already processed with the new alignment.
        replace_en = ((state == LOCKED) || start_beat) &&
                     !cfg_disable_char_replacement && cfg_disable_scrambler;

        pos       = start_beat ? 8'd0 : base;
        hist_data = prev_eof;
        hist_repl = prev_repl;

        // Lanes chain lane 0 first so several EOFs inside one beat see each other.
        for (int i = 0; i < DPW; i++) begin
            octet         = bus.in_data[8*i +: 8];
            is_align_char = bus.in_charisk[i] && ((octet == CHAR_A) || (octet == CHAR_F));
            if (pos == frame_last_next) begin
                if (IS_RX) begin
                    if (replace_en && is_align_char) begin
                        data_next[8*i +: 8] = hist_data;
                        hist_repl           = 1'b1;
                        if (octet == CHAR_A) begin
                            a_events = a_events + 4'd1;
                        end else begin
                            f_events = f_events + 4'd1;
                        end
                    end else begin
                        hist_data = octet;
                        hist_repl = 1'b0;
                    end
                end else begin
                    if (replace_en && (octet == hist_data) && bus.in_eomf[i]) begin
                        data_next[8*i +: 8] = CHAR_A;
                        charisk_next[i]     = 1'b1;
                        hist_repl           = 1'b1;
                        a_events            = a_events + 4'd1;
                    end else if (replace_en && (octet == hist_data) && !hist_repl) begin
                        data_next[8*i +: 8] = CHAR_F;
                        charisk_next[i]     = 1'b1;
                        hist_repl           = 1'b1;
                        f_events            = f_events + 4'd1;
                    end else begin
                        hist_repl = 1'b0;
                    end
                    hist_data = octet;
                end
                pos = 8'd0;
            end else begin
                if (IS_RX && replace_en && is_align_char) begin
                    unexpected_next = 1'b1;
                end
                pos = pos + 8'd1;
            end
        end

        if (bus.in_valid) begin
            base_next      = pos;
            prev_eof_next  = hist_data;
            prev_repl_next = hist_repl;
        end
    end

    // History, position and the registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_last              <= 8'd0;
            base                    <= 8'd0;
            prev_eof                <= 8'd0;
            prev_repl               <= 1'b0;
            bus.out_valid           <= 1'b0;
            bus.out_data            <= '0;
            bus.out_charisk         <= '0;
            bus.out_unexpected_char <= 1'b0;
        end else begin
            frame_last              <= frame_last_next;
            base                    <= base_next;
            prev_eof                <= prev_eof_next;
            prev_repl               <= prev_repl_next;
            bus.out_valid           <= bus.in_valid;
            bus.out_data            <= data_next;
            bus.out_charisk         <= bus.in_valid ? charisk_next : '0;
            bus.out_unexpected_char <= bus.in_valid && unexpected_next;
        end
    end

`ifdef JESD204_FRAME_ALIGN_STATS_EN
    logic [16:0] a_sum;
    logic [16:0] f_sum;
    assign a_sum = {1'b0, stat_a_count} + {13'd0, a_events};
    assign f_sum = {1'b0, stat_f_count} + {13'd0, f_events};

    // Saturating replacement counters, several events per beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_a_count <= 16'd0;
            stat_f_count <= 16'd0;
        end else if (bus.in_valid) begin
            stat_a_count <= a_sum[16] ? 16'hFFFF : a_sum[15:0];
            stat_f_count <= f_sum[16] ? 16'hFFFF : f_sum[15:0];
        end
    end
`else
    logic unused_events;
    assign unused_events = ^{a_events, f_events};
`endif

endmodule
